// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU store path: store-op encodings, the store
// FSM state encoding and a small alignment helper.
package cpu_pkg;

  localparam int unsigned DataW = 32;

  // Store op as presented on the stop bus.
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_W    = 2'b01,
    ST_H    = 2'b10,
    ST_B    = 2'b11
  } store_op_e;

  // Store-side FSM states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StMerge = 3'd2,
    StWrite = 3'd3,
    StFault = 3'd4
  } state_e;

  // A word store needs both low address bits clear; a halfword store needs
  // an even address. Bytes are always aligned.
  function automatic logic is_misaligned(store_op_e op, logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (op)
      ST_W:    mis = (lane != 2'b00);
      ST_H:    mis = lane[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/din_byte_merge.sv
// Combinational lane merge: drops the low byte/halfword of wr_data into the
// selected lane of old_word. A word op passes wr_data straight through.
module din_byte_merge
  import cpu_pkg::*;
(
  input  logic [DataW-1:0] old_word,
  input  logic [DataW-1:0] wr_data,
  input  store_op_e        op,
  input  logic [1:0]       lane,
  output logic [DataW-1:0] merged
);

  // Replace only the addressed lane; everything else keeps the old word.
  always_comb begin
    merged = old_word;
    case (op)
      ST_W: merged = wr_data;
      ST_H: begin
        if (lane[1]) begin
          merged[31:16] = wr_data[15:0];
        end else begin
          merged[15:0] = wr_data[15:0];
        end
      end
      ST_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wr_data[7:0];
          2'd1:    merged[15:8]  = wr_data[7:0];
          2'd2:    merged[23:16] = wr_data[7:0];
          default: merged[31:24] = wr_data[7:0];
        endcase
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/din_merger.sv
// Store-side data path towards a word-only data memory. Word stores write
// directly; byte/halfword stores read the word, merge the lane and write it
// back. Misaligned requests pulse err and never touch memory.
module din_merger
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  stop,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  state_e          state_q;
  store_op_e       op_q;
  logic [1:0]      lane_q;
  logic [31:0]     data_q;

  store_op_e       op_in;
  store_op_e       merge_op;
  logic [1:0]      merge_lane;
  logic [31:0]     merge_old;
  logic [31:0]     merge_data;
  logic [31:0]     merged;

  assign op_in = store_op_e'(stop);

  // In IDLE the merger sees the live request (only a word store uses the
  // result there, so old word is irrelevant); in MERGE it sees the latched
  // request and the word returned by memory.
  always_comb begin
    merge_op   = op_q;
    merge_lane = lane_q;
    merge_data = data_q;
    merge_old  = mem_rdata;
    if (state_q == StIdle) begin
      merge_op   = op_in;
      merge_lane = addr[1:0];
      merge_data = rt_data;
      merge_old  = '0;
    end
  end

  din_byte_merge u_byte_merge (
    .old_word (merge_old),
    .wr_data  (merge_data),
    .op       (merge_op),
    .lane     (merge_lane),
    .merged   (merged)
  );

  // Store FSM; every output is a register so nothing combinational reaches
  // the pins from the request inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= ST_NONE;
      lane_q    <= 2'b00;
      data_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      done      <= 1'b0;
      err       <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      case (state_q)
        StIdle: begin
          if (start && (op_in != ST_NONE)) begin
            op_q     <= op_in;
            lane_q   <= addr[1:0];
            data_q   <= rt_data;
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            if (is_misaligned(op_in, addr[1:0])) begin
              state_q <= StFault;
              err     <= 1'b1;
            end else if (op_in == ST_W) begin
              state_q   <= StWrite;
              mem_we    <= 1'b1;
              done      <= 1'b1;
              mem_wdata <= merged;
            end else begin
              state_q <= StRead;
              mem_re  <= 1'b1;
            end
          end
        end
        StRead: begin
          // Read strobe was issued on entry; data arrives during MERGE.
          state_q <= StMerge;
        end
        StMerge: begin
          state_q   <= StWrite;
          mem_we    <= 1'b1;
          done      <= 1'b1;
          mem_wdata <= merged;
        end
        StWrite, StFault: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
